// File: rtl/bus_control_pkg.sv
// Shared types and constants for the bus control sequencer: FSM states,
// decoded data-bit positions and commit-strobe indices.
package bus_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ICW2,
    ST_WAIT_ICW3,
    ST_WAIT_ICW4,
    ST_READY
  } state_e;

  localparam int BIT_IC4  = 0;
  localparam int BIT_SNGL = 1;
  localparam int BIT_D3   = 3;
  localparam int BIT_D4   = 4;

  localparam int STB_ICW1 = 0;
  localparam int STB_ICW2 = 1;
  localparam int STB_ICW3 = 2;
  localparam int STB_ICW4 = 3;
  localparam int STB_OCW1 = 4;
  localparam int STB_OCW2 = 5;
  localparam int STB_OCW3 = 6;
  localparam int NUM_STB  = 7;

endpackage

// File: rtl/bus_control_sync.sv
// Input sampler: a STAGES-deep flop chain when BUS_CONTROL_SYNC_EN is defined,
// otherwise a single register stage. Reset loads RESET_VAL into every stage.
module bus_control_sync #(
  parameter int                 WIDTH     = 13,
  parameter int                 STAGES    = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

`ifdef BUS_CONTROL_SYNC_EN
  localparam int DEPTH = STAGES;
`else
  localparam int DEPTH = 1;
`endif

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("bus_control_sync: STAGES must be 2 to 4");
  end

  logic [WIDTH-1:0] chain_d [DEPTH];
  logic [WIDTH-1:0] chain_q [DEPTH];

  always_comb begin
    chain_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        chain_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        chain_q[i] <= chain_d[i];
      end
    end
  end

  assign dout = chain_q[DEPTH-1];

endmodule

// File: rtl/bus_control_sequencer.sv
// Host bus write/read sequencer: detects write commits, decodes ICW1-4 and
// OCW1-3 and tracks the init sequence. Sampler depth follows BUS_CONTROL_SYNC_EN.
module bus_control_sequencer
  import bus_control_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_select_n,
  input  logic                  read_enable_n,
  input  logic                  write_enable_n,
  input  logic                  address,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] internal_data_bus,
  output logic                  write_icw1,
  output logic                  write_icw2,
  output logic                  write_icw3,
  output logic                  write_icw4,
  output logic                  write_ocw1,
  output logic                  write_ocw2,
  output logic                  write_ocw3,
  output logic                  read,
  output logic                  init_done
);

  localparam int SW = DATA_WIDTH + 5;
  // The top bit marks a genuine sample; it is 0 while reset values flush out.
  localparam logic [SW-1:0] SYNC_RST = {1'b0, 3'b111, 1'b0, {DATA_WIDTH{1'b0}}};

  logic [SW-1:0]         sync_in, sync_out;
  logic                  s_valid, s_cs_n, s_rd_n, s_wr_n, s_a0;
  logic [DATA_WIDTH-1:0] s_data;

  assign sync_in = {1'b1, chip_select_n, read_enable_n, write_enable_n, address, data_bus_in};
  assign {s_valid, s_cs_n, s_rd_n, s_wr_n, s_a0, s_data} = sync_out;

  bus_control_sync #(
    .WIDTH    (SW),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(SYNC_RST)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .din  (sync_in),
    .dout (sync_out)
  );

  state_e                state_d, state_q;
  logic                  sngl_d, sngl_q, ic4_d, ic4_q;
  logic                  wr_act_d, wr_act_q, wr_block_d, wr_block_q;
  logic                  cap_a0_d, cap_a0_q;
  logic [DATA_WIDTH-1:0] cap_data_d, cap_data_q;
  logic [DATA_WIDTH-1:0] bus_d, bus_q;
  logic [NUM_STB-1:0]    strb_d, strb_q;
  logic                  read_d, read_q, init_done_d, init_done_q;
  logic                  wr_now, commit;

  always_comb begin
    state_d     = state_q;
    sngl_d      = sngl_q;
    ic4_d       = ic4_q;
    bus_d       = bus_q;
    strb_d      = '0;
    wr_now      = !s_cs_n && !s_wr_n;
    // A write in flight across reset stays blocked until a real wr_n=1 is seen.
    wr_act_d    = wr_now && !wr_block_q;
    wr_block_d  = wr_block_q && !(s_valid && s_wr_n);
    cap_a0_d    = wr_act_d ? s_a0 : cap_a0_q;
    cap_data_d  = wr_act_d ? s_data : cap_data_q;
    commit      = s_wr_n && wr_act_q;
    read_d      = !s_cs_n && !s_rd_n && !wr_now;

    if (commit) begin
      if (!cap_a0_q) begin
        if (cap_data_q[BIT_D4]) begin
          bus_d            = cap_data_q;
          strb_d[STB_ICW1] = 1'b1;
          sngl_d           = cap_data_q[BIT_SNGL];
          ic4_d            = cap_data_q[BIT_IC4];
          state_d          = ST_WAIT_ICW2;
        end else if (state_q == ST_READY) begin
          bus_d = cap_data_q;
          if (cap_data_q[BIT_D3]) strb_d[STB_OCW3] = 1'b1;
          else                    strb_d[STB_OCW2] = 1'b1;
        end
      end else begin
        case (state_q)
          ST_WAIT_ICW2: begin
            bus_d            = cap_data_q;
            strb_d[STB_ICW2] = 1'b1;
            if (!sngl_q)     state_d = ST_WAIT_ICW3;
            else if (ic4_q)  state_d = ST_WAIT_ICW4;
            else             state_d = ST_READY;
          end
          ST_WAIT_ICW3: begin
            bus_d            = cap_data_q;
            strb_d[STB_ICW3] = 1'b1;
            state_d          = ic4_q ? ST_WAIT_ICW4 : ST_READY;
          end
          ST_WAIT_ICW4: begin
            bus_d            = cap_data_q;
            strb_d[STB_ICW4] = 1'b1;
            state_d          = ST_READY;
          end
          ST_READY: begin
            bus_d            = cap_data_q;
            strb_d[STB_OCW1] = 1'b1;
          end
          default: ;
        endcase
      end
    end

    init_done_d = (state_d == ST_READY);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      wr_act_q    <= 1'b0;
      wr_block_q  <= 1'b1;
      bus_q       <= '0;
      strb_q      <= '0;
      read_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      wr_act_q    <= wr_act_d;
      wr_block_q  <= wr_block_d;
      bus_q       <= bus_d;
      strb_q      <= strb_d;
      read_q      <= read_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clock) begin
    cap_a0_q   <= cap_a0_d;
    cap_data_q <= cap_data_d;
  end

  assign internal_data_bus = bus_q;
  assign write_icw1        = strb_q[STB_ICW1];
  assign write_icw2        = strb_q[STB_ICW2];
  assign write_icw3        = strb_q[STB_ICW3];
  assign write_icw4        = strb_q[STB_ICW4];
  assign write_ocw1        = strb_q[STB_OCW1];
  assign write_ocw2        = strb_q[STB_OCW2];
  assign write_ocw3        = strb_q[STB_OCW3];
  assign read              = read_q;
  assign init_done         = init_done_q;

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Self-checking bench for bus_control_sequencer: directed and random host
// writes against a transaction-level model; valid with or without BUS_CONTROL_SYNC_EN.
module tb_bus_control_sequencer;

  localparam int SYNC_STAGES = 2;
`ifdef BUS_CONTROL_SYNC_EN
  localparam int EXP_LAT = SYNC_STAGES + 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic       clock = 1'b0;
  logic       reset, cs_n, rd_n, wr_n, a0;
  logic [7:0] din, bus;
  logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, rd, init_done;

  int n_chk  = 0;
  int n_fail = 0;

  bus_control_sequencer #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clock            (clock),
    .reset            (reset),
    .chip_select_n    (cs_n),
    .read_enable_n    (rd_n),
    .write_enable_n   (wr_n),
    .address          (a0),
    .data_bus_in      (din),
    .internal_data_bus(bus),
    .write_icw1       (icw1),
    .write_icw2       (icw2),
    .write_icw3       (icw3),
    .write_icw4       (icw4),
    .write_ocw1       (ocw1),
    .write_ocw2       (ocw2),
    .write_ocw3       (ocw3),
    .read             (rd),
    .init_done        (init_done)
  );

  always #5 clock = ~clock;

  // Reference model: ICW1 builds the list of A0=1 init words still owed;
  // once that list is empty the device is ready.
  bit         m_seen_icw1;
  int         m_pending[$];
  logic [7:0] m_bus;

  function automatic bit m_ready();
    return m_seen_icw1 && (m_pending.size() == 0);
  endfunction

  function automatic void m_reset();
    m_seen_icw1 = 0;
    m_pending.delete();
    m_bus = 8'h00;
  endfunction

  // Returns strobe index 0..6 (icw1..icw4, ocw1..ocw3) or -1 for none.
  function automatic int m_write(input logic wa0, input logic [7:0] wd);
    if (!wa0 && wd[4]) begin
      m_seen_icw1 = 1;
      m_pending.delete();
      m_pending.push_back(1);
      if (!wd[1]) m_pending.push_back(2);
      if (wd[0])  m_pending.push_back(3);
      m_bus = wd;
      return 0;
    end
    if (!wa0) begin
      if (!m_ready()) return -1;
      m_bus = wd;
      return wd[3] ? 6 : 5;
    end
    if (!m_seen_icw1) return -1;
    m_bus = wd;
    if (m_pending.size() != 0) return m_pending.pop_front();
    return 4;
  endfunction

  function automatic logic [6:0] strobes();
    return {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic watch(input int cycles, output logic [6:0] seen, output int highs,
                       output int lat, output int rd_highs);
    logic [6:0] s;
    seen = '0; highs = 0; lat = 0; rd_highs = 0;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clock);
      if (k == 1) cs_n = 1'b1;
      s = strobes();
      if (s != 0) begin
        seen  |= s;
        highs += $countones(s);
        if (lat == 0) lat = k;
      end
      if (rd) rd_highs++;
    end
  endtask

  task automatic do_write(input logic wa0, input logic [7:0] wd, input int hold,
                          input bit cs_late, input bit abort, input bit with_rd,
                          input string tag);
    int exp_idx, highs, lat, rd_pre, rd_post;
    logic [6:0] seen, exp_vec;
    rd_pre = 0;
    @(negedge clock);
    cs_n = 1'b0; wr_n = 1'b0; a0 = wa0; din = wd;
    if (with_rd) rd_n = 1'b0;
    repeat (hold) begin
      @(negedge clock);
      if (rd) rd_pre++;
    end
    if (abort) begin
      cs_n = 1'b1;
      @(negedge clock);
      if (rd) rd_pre++;
    end
    wr_n = 1'b1;
    rd_n = 1'b1;
    if (!cs_late) cs_n = 1'b1;
    watch(10, seen, highs, lat, rd_post);
    exp_idx = abort ? -1 : m_write(wa0, wd);
    exp_vec = (exp_idx < 0) ? 7'd0 : (7'd1 << exp_idx);
    check({tag, ".strobe"}, {25'd0, seen}, {25'd0, exp_vec});
    check({tag, ".pulses"}, highs, (exp_idx < 0) ? 0 : 1);
    check({tag, ".bus"}, {24'd0, bus}, {24'd0, m_bus});
    check({tag, ".init_done"}, {31'd0, init_done}, {31'd0, m_ready()});
    if (exp_idx >= 0) check({tag, ".latency"}, lat, EXP_LAT);
    check({tag, ".read"}, rd_pre + rd_post, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (3) @(negedge clock);
    check("rst.strobes", {25'd0, strobes()}, 32'd0);
    check("rst.bus", {24'd0, bus}, 32'd0);
    check("rst.read", {31'd0, rd}, 32'd0);
    check("rst.init_done", {31'd0, init_done}, 32'd0);
    reset = 1'b0;
    m_reset();
    repeat (5) @(negedge clock);
  endtask

  logic       r_a0;
  logic [7:0] r_d;
  int         kind, highs, lat, rdh;
  logic [6:0] seen;

  initial begin
    reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
    m_reset();
    do_reset();

    do_write(1'b1, 8'h55, 2, 0, 0, 0, "idle_a0");
    do_write(1'b0, 8'h10, 2, 0, 0, 0, "icw1");
    do_write(1'b1, 8'h20, 1, 1, 0, 0, "icw2");
    do_write(1'b1, 8'h00, 3, 0, 0, 0, "icw3");
    do_write(1'b1, 8'hFF, 2, 0, 0, 0, "ocw1");
    do_write(1'b0, 8'h20, 2, 1, 0, 0, "ocw2");
    do_write(1'b0, 8'h08, 1, 0, 0, 0, "ocw3");

    @(negedge clock);
    cs_n = 1'b0; rd_n = 1'b0;
    repeat (6) @(negedge clock);
    check("rd.active", {31'd0, rd}, 32'd1);
    cs_n = 1'b1; rd_n = 1'b1;
    repeat (6) @(negedge clock);
    check("rd.idle", {31'd0, rd}, 32'd0);
    do_write(1'b1, 8'h5A, 4, 0, 0, 1, "rdwr");

    do_write(1'b0, 8'h10, 2, 0, 0, 0, "rs_icw1");
    do_write(1'b1, 8'h20, 2, 0, 0, 0, "rs_icw2");
    do_write(1'b0, 8'h11, 2, 0, 0, 0, "rs_restart");
    do_write(1'b1, 8'h33, 2, 0, 0, 0, "rs_icw2b");
    do_write(1'b1, 8'h44, 2, 0, 0, 0, "rs_icw3b");
    do_write(1'b1, 8'h01, 2, 0, 0, 0, "rs_icw4b");

    do_write(1'b0, 8'h13, 2, 0, 0, 0, "s_icw1");
    do_write(1'b1, 8'h20, 2, 0, 0, 0, "s_icw2");
    do_write(1'b1, 8'h01, 2, 0, 0, 0, "s_icw4");

    do_write(1'b0, 8'h10, 2, 0, 0, 0, "nr_icw1");
    do_write(1'b0, 8'h20, 2, 0, 0, 0, "nr_ocw2");
    do_write(1'b0, 8'h08, 2, 0, 0, 0, "nr_ocw3");
    do_write(1'b1, 8'hAA, 2, 0, 1, 0, "abort");
    do_write(1'b1, 8'h20, 2, 0, 0, 0, "ab_icw2");
    do_write(1'b1, 8'h00, 2, 0, 0, 0, "ab_icw3");

    @(negedge clock);
    cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b0; din = 8'h10;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_reset();
    repeat (3) @(negedge clock);
    wr_n = 1'b1;
    watch(10, seen, highs, lat, rdh);
    check("rstmid.strobe", {25'd0, seen}, 32'd0);
    check("rstmid.bus", {24'd0, bus}, 32'd0);
    check("rstmid.init_done", {31'd0, init_done}, 32'd0);
    repeat (3) @(negedge clock);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      r_d  = 8'($urandom_range(0, 255));
      if (kind < 2) begin
        r_a0 = 1'b0; r_d[4] = 1'b1;
      end else if (kind < 6) begin
        r_a0 = 1'b1;
      end else begin
        r_a0 = 1'b0; r_d[4] = 1'b0;
      end
      do_write(r_a0, r_d, $urandom_range(1, 3), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 7) == 0), 0, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
